// File: rtl/store_merge_unit_if.sv
// Bus bundle for store_merge_unit: datapath store request, data memory port and status pulses.
// slave is the store unit's view; master is the requester/memory side.
interface store_merge_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [1:0]  req_size;
    logic [29:0] mem_addr;
    logic        mem_rd_en;
    logic [31:0] mem_rd_data;
    logic        mem_rd_valid;
    logic        mem_wr_en;
    logic [31:0] mem_wr_data;
    logic [3:0]  mem_be;
    logic        done;
    logic        err;

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_rd_data, mem_rd_valid,
        output req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, mem_be, done, err
    );

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_rd_data, mem_rd_valid,
        input  req_ready, mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, mem_be, done, err
    );
endinterface

// File: rtl/store_merge_unit.sv
// Narrows a register value to sb/sh/sw and merges it into word-addressed memory.
// Optional macro BYTE_ENABLE_EN: sub-word stores use byte enables instead of read-modify-write.
module store_merge_unit #(
    parameter int unsigned READ_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    store_merge_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = READ_TIMEOUT[7:0];

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [29:0] addr_reg;
    logic [1:0]  off_reg;
    logic [1:0]  size_reg;
    logic [31:0] wdata_reg;
    logic        req_ok;
    logic        accept;
    logic [3:0]  rmw_mask;
    logic [31:0] rmw_rep;
    logic [31:0] merged;
    logic        ready_c, rd_en_c, wr_en_c, done_c, err_c;

    // Lanes touched by a store of the given size at byte offset off.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] m;
        m = 4'b1111;
        case (size)
            2'b00:   m = 4'b0001 << off;
            2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    // Store data replicated so every lane carries the bytes it would receive.
    function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] d);
        logic [31:0] r;
        r = d;
        case (size)
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        req_ok = 1'b1;
        case (bus.req_size)
            2'b01:   req_ok = ~bus.req_addr[0];
            2'b10:   req_ok = (bus.req_addr[1:0] == 2'b00);
            2'b11:   req_ok = 1'b0;
            default: req_ok = 1'b1;
        endcase
    end

    assign accept   = (state_reg == IDLE) && bus.req_valid;
    assign rmw_mask = lane_mask(size_reg, off_reg);
    assign rmw_rep  = lane_rep(size_reg, wdata_reg);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign merged[8*gi +: 8] = rmw_mask[gi] ? rmw_rep[8*gi +: 8]
                                                    : bus.mem_rd_data[8*gi +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ready_c    = 1'b0;
        rd_en_c    = 1'b0;
        wr_en_c    = 1'b0;
        done_c     = 1'b0;
        err_c      = 1'b0;
        case (state_reg)
            IDLE: begin
                ready_c  = 1'b1;
                cnt_next = 8'd0;
                if (bus.req_valid) begin
                    if (!req_ok)
                        state_next = ERR;
                    else if (bus.req_size == 2'b10)
                        state_next = WRITE;
                    else
`ifdef BYTE_ENABLE_EN
                        state_next = WRITE;
`else
                        state_next = READ;
`endif
                end
            end
            READ: begin
                rd_en_c    = 1'b1;
                state_next = WAIT;
            end
            WAIT: begin
                if (bus.mem_rd_valid) begin
                    cnt_next   = 8'd0;
                    state_next = WRITE;
                end else if (cnt_reg + 8'd1 == TIMEOUT_LIM) begin
                    cnt_next   = 8'd0;
                    state_next = ERR;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            WRITE: begin
                wr_en_c    = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end
            ERR: begin
                err_c      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef BYTE_ENABLE_EN
    logic [3:0] be_reg;
`endif

    // Request fields are captured once at accept; wdata_reg later holds the merged word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_reg  <= 30'd0;
            off_reg   <= 2'd0;
            size_reg  <= 2'd0;
            wdata_reg <= 32'd0;
`ifdef BYTE_ENABLE_EN
            be_reg    <= 4'b1111;
`endif
        end else begin
            if (accept) begin
                addr_reg <= bus.req_addr[31:2];
                off_reg  <= bus.req_addr[1:0];
                size_reg <= bus.req_size;
`ifdef BYTE_ENABLE_EN
                wdata_reg <= lane_rep(bus.req_size, bus.req_data);
                be_reg    <= lane_mask(bus.req_size, bus.req_addr[1:0]);
`else
                wdata_reg <= bus.req_data;
`endif
            end else if (state_reg == WAIT && bus.mem_rd_valid) begin
                wdata_reg <= merged;
            end
        end
    end

    assign bus.req_ready   = ready_c;
    assign bus.mem_addr    = addr_reg;
    assign bus.mem_rd_en   = rd_en_c;
    assign bus.mem_wr_en   = wr_en_c;
    assign bus.mem_wr_data = wdata_reg;
    assign bus.done        = done_c;
    assign bus.err         = err_c;
`ifdef BYTE_ENABLE_EN
    assign bus.mem_be      = be_reg;
`else
    assign bus.mem_be      = 4'b1111;
`endif

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit; memory writes are checked against a queue of expected writes.
// Honours BYTE_ENABLE_EN when defined for the build.
module tb_store_merge_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   rd_cnt = 0;
    int   wr_cnt = 0;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    wr_t exp_q[$];

    store_merge_unit_if bus();

    store_merge_unit #(.READ_TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Write monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.mem_rd_en) rd_cnt++;
        if (bus.mem_wr_en) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 32'(bus.mem_wr_en), 32'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                chk("wr_data", bus.mem_wr_data, e.data);
                chk("wr_be", 32'(bus.mem_be), 32'(e.be));
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 40 && !bus.req_ready; i++) tick();
        chk("ready_wait", 32'(bus.req_ready), 32'd1);
    endtask

    // Drive one request, play memory (read word after n cycles) and check timing.
    task automatic run_store(input string tag, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, input logic [31:0] memw, input int n,
                             input logic [31:0] expw, input logic [3:0] expbe);
        logic direct;
        int   rd0;
        wr_t  e;
        direct = (sz == 2'b10);
`ifdef BYTE_ENABLE_EN
        direct = 1'b1;
`endif
        e.addr = a[31:2];
        e.data = expw;
        e.be   = expbe;
        exp_q.push_back(e);
        wait_ready();
        rd0 = rd_cnt;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = d;
        bus.req_size  = sz;
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_data  = 32'h0;
        bus.req_size  = 2'b11;
        chk({tag, "_ready_busy"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'(a[31:2]));
        if (!direct) begin
            chk({tag, "_rd_en"}, 32'(bus.mem_rd_en), 32'd1);
            repeat (n) tick();
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = memw;
            tick();
            bus.mem_rd_valid = 1'b0;
            bus.mem_rd_data  = 32'h0;
        end
        chk({tag, "_wr_en"}, 32'(bus.mem_wr_en), 32'd1);
        chk({tag, "_wr_done_low"}, 32'(bus.done), 32'd0);
        tick();
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_rd_count"}, 32'(rd_cnt - rd0), direct ? 32'd0 : 32'd1);
        tick();
        chk({tag, "_ready_again"}, 32'(bus.req_ready), 32'd1);
    endtask

    task automatic run_bad(input string tag, input logic [31:0] a, input logic [1:0] sz);
        int rd0, wr0;
        wait_ready();
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_data  = 32'h5555_AAAA;
        bus.req_size  = sz;
        tick();
        bus.req_valid = 1'b0;
        chk({tag, "_err"}, 32'(bus.err), 32'd1);
        chk({tag, "_ready_busy"}, 32'(bus.req_ready), 32'd0);
        tick();
        chk({tag, "_err_pulse"}, 32'(bus.err), 32'd0);
        chk({tag, "_ready_back"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_no_access"}, 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n            = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_data     = 32'h0;
        bus.req_size     = 2'b00;
        bus.mem_rd_data  = 32'h0;
        bus.mem_rd_valid = 1'b0;
        tick();
        tick();
        chk("rst_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_strobes", {28'd0, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.err}, 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_wr_data", bus.mem_wr_data, 32'd0);
        chk("rst_be", 32'(bus.mem_be), 32'hF);
        rst_n = 1'b1;
        tick();

        run_store("sw", 32'h0000_0010, 32'hDEAD_BEEF, 2'b10, 32'h0, 0, 32'hDEAD_BEEF, 4'b1111);
`ifdef BYTE_ENABLE_EN
        run_store("sb", 32'h0000_0013, 32'h0000_00AB, 2'b00, 32'h1122_3344, 2, 32'hABAB_ABAB, 4'b1000);
        run_store("sh", 32'h0000_0022, 32'hFFFF_1234, 2'b01, 32'hCAFE_BABE, 1, 32'h1234_1234, 4'b1100);
        run_store("sb1", 32'h0000_0041, 32'h0000_005A, 2'b00, 32'h0, 3, 32'h5A5A_5A5A, 4'b0010);
        run_store("sh0", 32'h0000_0080, 32'h0000_9876, 2'b01, 32'h0, 1, 32'h9876_9876, 4'b0011);
`else
        run_store("sb", 32'h0000_0013, 32'h0000_00AB, 2'b00, 32'h1122_3344, 2, 32'hAB22_3344, 4'b1111);
        run_store("sh", 32'h0000_0022, 32'hFFFF_1234, 2'b01, 32'hCAFE_BABE, 1, 32'h1234_BABE, 4'b1111);
        run_store("sb1", 32'h0000_0041, 32'h0000_005A, 2'b00, 32'h0000_0000, 3, 32'h0000_5A00, 4'b1111);
        run_store("sh0", 32'h0000_0080, 32'h0000_9876, 2'b01, 32'hFFFF_FFFF, 1, 32'hFFFF_9876, 4'b1111);
`endif
        run_store("sw2", 32'hFFFF_FFFC, 32'h0123_4567, 2'b10, 32'h0, 0, 32'h0123_4567, 4'b1111);

        run_bad("sh_mis", 32'h0000_0021, 2'b01);
        run_bad("sz_ill", 32'h0000_0020, 2'b11);
        run_bad("sw_mis", 32'h0000_0022, 2'b10);

`ifndef BYTE_ENABLE_EN
        begin
            int wr0, err_at;
            wait_ready();
            wr0 = wr_cnt;
            err_at = -1;
            bus.req_valid = 1'b1;
            bus.req_addr  = 32'h0000_0031;
            bus.req_data  = 32'h0000_0077;
            bus.req_size  = 2'b00;
            tick();
            bus.req_valid = 1'b0;
            for (int c = 1; c <= 40 && err_at < 0; c++) begin
                if (bus.err) err_at = c;
                else tick();
            end
            chk("timeout_err_cycle", 32'(err_at), 32'd17);
            chk("timeout_no_write", 32'(wr_cnt - wr0), 32'd0);
            tick();
            chk("timeout_ready", 32'(bus.req_ready), 32'd1);
        end

        begin
            int wr0;
            wait_ready();
            wr0 = wr_cnt;
            bus.req_valid = 1'b1;
            bus.req_addr  = 32'h0000_0052;
            bus.req_data  = 32'h0000_4321;
            bus.req_size  = 2'b01;
            tick();
            bus.req_valid = 1'b0;
            tick();
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            chk("rst_wait_ready", 32'(bus.req_ready), 32'd1);
            chk("rst_wait_strobes", {28'd0, bus.mem_rd_en, bus.mem_wr_en, bus.done, bus.err}, 32'd0);
            chk("rst_wait_addr", 32'(bus.mem_addr), 32'd0);
            chk("rst_wait_data", bus.mem_wr_data, 32'd0);
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = 32'hAAAA_AAAA;
            tick();
            bus.mem_rd_valid = 1'b0;
            repeat (4) tick();
            chk("rst_wait_no_write", 32'(wr_cnt - wr0), 32'd0);
            chk("rst_wait_idle", 32'(bus.req_ready), 32'd1);
        end
`endif

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_merge_unit.md
Name: store_merge_unit

Overview:
Store-side counterpart of the load-path sign extender: narrows a 32-bit register value to a byte, halfword or word and merges it into word-addressed data memory (sb/sh/sw).
- Sits between the datapath store request and the data memory port.
- Performs read-modify-write for sub-word stores.
- Flags misaligned or illegal requests and memory read timeouts.

Parameters:
READ_TIMEOUT, 15, max cycles waiting for mem_rd_valid before aborting with error (1..255)

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  reset; synchronous, active-low
req_valid  input  1  store request valid
req_ready  output  1  unit idle, accepts request this cycle
req_addr  input  32  byte address of store
req_data  input  32  register value; low bits used for sb/sh
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
mem_addr  output  30  word address (req_addr[31:2]), held for whole transaction
mem_rd_en  output  1  one-cycle read strobe
mem_rd_data  input  32  read word
mem_rd_valid  input  1  mem_rd_data valid this cycle
mem_wr_en  output  1  one-cycle write strobe
mem_wr_data  output  32  merged word to write
mem_be  output  4  byte enables for the write
done  output  1  one-cycle pulse, store completed
err  output  1  one-cycle pulse, request rejected or aborted

Behaviour:
- Reset (rst_n=0 at clock edge), including mid-transaction:
  - state IDLE, timeout counter 0, no write issued.
  - req_ready=1; mem_rd_en, mem_wr_en, done, err = 0; mem_addr, mem_wr_data = 0; mem_be=4'b1111.
- Handshake: request accepted at the edge where req_valid && req_ready. Addr/data/size are latched then; inputs are don't-care afterwards. req_ready=1 only in IDLE.
- Byte lanes are little-endian: offset k=addr[1:0] maps to bits [8k+7:8k]. Halfword at addr[1]=0 uses [15:0], at addr[1]=1 uses [31:16].
- Validity check at accept:
  - size 11 is illegal.
  - halfword with addr[0]=1 is misaligned.
  - word with addr[1:0]!=0 is misaligned.
  - Illegal or misaligned requests go to ERR: err=1 for one cycle, no memory access, then IDLE.
- FSM states: IDLE, READ, WAIT, WRITE, DONE, ERR.
  - IDLE -> WRITE: word accepted.
  - IDLE -> READ: byte or halfword accepted.
  - IDLE -> ERR: invalid request.
  - READ: mem_rd_en=1 for exactly one cycle -> WAIT.
  - WAIT, mem_rd_valid=1: merge. Keep unselected bytes of mem_rd_data, replace selected lane(s) with req_data[7:0] or [15:0], register the result -> WRITE. mem_rd_valid is sampled only in WAIT.
  - WAIT, mem_rd_valid=0: counter increments. When the counter reaches READ_TIMEOUT -> ERR.
  - WRITE: mem_wr_en=1 for one cycle with mem_wr_data and mem_be=4'b1111 -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Latency from the accept edge:
  - Word: mem_wr_en in cycle +1, done in +2, req_ready again in +3.
  - Sub-word with mem_rd_valid N cycles after mem_rd_en: write in cycle +2+N, done in +3+N.
- Back-to-back requests: the next request can be accepted in the cycle after done.
- mem_addr is stable from the first cycle after accept through WRITE.

Optional Feature:
BYTE_ENABLE_EN
- Defined: sub-word stores skip READ/WAIT and go IDLE -> WRITE directly.
  - mem_wr_data carries the byte or halfword replicated to all lanes.
  - mem_be selects the lanes: byte = 1<<k; halfword = 0011 or 1100.
  - Latency is the same as a word store; timeout logic is unused.
- Undefined: read-modify-write path as above, mem_be fixed at 4'b1111.

Test Plan:
- Word store addr=0x00000010, data=0xDEADBEEF -> mem_addr=0x4, mem_wr_data=0xDEADBEEF at cycle +1, done at +2, no mem_rd_en.
- Byte store addr=0x00000013, data=0x000000AB, memory returns 0x11223344 after 2 cycles -> mem_wr_data=0xAB223344, done at +5.
- Halfword store addr=0x00000022, data=0xFFFF1234, memory word 0xCAFEBABE -> mem_wr_data=0x1234BABE; with BYTE_ENABLE_EN: mem_wr_data=0x12341234, mem_be=1100, no read.
- Halfword addr=0x00000021 and size=11 -> err pulse one cycle after accept, no mem_rd_en/mem_wr_en, req_ready back next cycle.
- Byte store with mem_rd_valid never asserted -> err after READ_TIMEOUT=15 WAIT cycles, mem_wr_en never asserted.
- rst_n=0 during WAIT -> next cycle state IDLE, req_ready=1, later mem_rd_valid ignored, no write.
